uart_rx: RTL and testbench

Asynchronous serial receiver for the iohub: 8N1, LSB first, 16x oversampling. It turns the pad-side line `rx_i` into one byte plus a one-cycle `received` strobe. Its outputs drive the header/payload framing stage, which uses `rx_byte` and `received` to detect the 0x80 header and assemble 16-bit words. All logic runs in the single system clock domain. `rx_i` is the only asynchronous input.

---
 rtl/iohub_pkg.sv | 23 ++
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/iohub_pkg.sv
// Shared iohub definitions: UART receiver state encodings and oversampling constants.
// No logic; imported by the UART blocks.
package iohub_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE,
        S_START = START,
        S_DATA  = DATA,
        S_STOP  = STOP,
        S_BRK   = BRK
    } rx_state_t;

    localparam int OVERSAMPLE      = 16;
    localparam int MID_SAMPLE      = 7;
    localparam int CLK_DIV_DEFAULT = 27;

endpackage

// File: rtl/uart_rx_if.sv
// Pad-side serial line plus received-byte strobes of the UART receiver.
// The slave modport is the receiver; master is the line driver / byte consumer.
interface uart_rx_if;
    logic       rx_i;
    logic [7:0] rx_byte;
    logic       received;
    logic       frame_err;
    logic       busy;

    modport master (output rx_i, input rx_byte, received, frame_err, busy);
    modport slave  (input rx_i, output rx_byte, received, frame_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, restartable via clr.
// Tick is combinational from the counter; clr takes effect on the next edge. No backpressure.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr,
    output logic tick
);
    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] tick_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_cnt <= '0;
        end else if (clr || tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with 16x oversampling; byte + strobe at p+3+152*CLK_DIV.
// Strobes are single-cycle flop outputs; there is no backpressure, consumers must take them.
module uart_rx
    import iohub_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    uart_rx_if.slave   rx_if
);
    logic       rx_m, rx_s;
    logic       clr, tick;
    rx_state_t  state;
    logic [3:0] smp_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] sh;
    logic [7:0] rx_byte_q;
    logic       received_q, frame_err_q, busy_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_if.rx_i;
            rx_s <= rx_m;
        end
    end

    // Holding the divider in reset while idle aligns tick k to d + k*CLK_DIV.
    assign clr = (state == S_IDLE);

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (clr),
        .tick    (tick)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_BRK;
            smp_cnt     <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            rx_byte_q   <= '0;
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                S_BRK: begin
                    if (rx_s) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    smp_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) begin
                        state  <= S_START;
                        busy_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (smp_cnt == 4'(MID_SAMPLE)) begin
                            smp_cnt <= '0;
                            if (!rx_s) begin
                                state <= S_DATA;
                            end else begin
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + 1'b1;
                        if (smp_cnt == 4'(OVERSAMPLE - 1)) begin
                            sh <= {rx_s, sh[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state <= S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + 1'b1;
                        if (smp_cnt == 4'(OVERSAMPLE - 1)) begin
                            if (rx_s) begin
                                rx_byte_q  <= sh;
                                received_q <= 1'b1;
                                state      <= S_IDLE;
                                busy_q     <= 1'b0;
                            end else begin
                                // Line still low: stay out of IDLE until it returns high.
                                frame_err_q <= 1'b1;
                                state       <= S_BRK;
                            end
                        end
                    end
                end
                default: begin
                    state  <= S_BRK;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign rx_if.rx_byte   = rx_byte_q;
    assign rx_if.received  = received_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frame-level model of strobe times, bytes and busy windows.
module tb_uart_rx;
    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;
    localparam int LAT = 3 + 152 * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    uart_rx_if u ();

    uart_rx #(.CLK_DIV(DIV)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .rx_if   (u)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; bit ok; logic [7:0] b; } ev_t;
    typedef struct { int s; int e; } win_t;

    ev_t        evq[$];
    win_t       wins[$];
    logic [7:0] mbyte = 8'h00;
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;
    int         rcv_cyc[$];
    logic [7:0] rcv_b[$];
    int         fe_cnt = 0;

    logic       exp_rcv, exp_fe, exp_busy;
    logic [10:0] exp_v, got_v;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_rcv = 1'b0;
            exp_fe  = 1'b0;
            if (evq.size() > 0 && evq[0].c == cyc) begin
                if (evq[0].ok) begin
                    exp_rcv = 1'b1;
                    mbyte   = evq[0].b;
                end else begin
                    exp_fe = 1'b1;
                end
                void'(evq.pop_front());
            end
            while (wins.size() > 0 && wins[0].e < cyc) void'(wins.pop_front());
            exp_busy = 1'b0;
            foreach (wins[i]) if (cyc >= wins[i].s && cyc <= wins[i].e) exp_busy = 1'b1;
            exp_v = {exp_rcv, exp_fe, exp_busy, mbyte};
            got_v = {u.received, u.frame_err, u.busy, u.rx_byte};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_outputs @%0d: got rcv=%b fe=%b busy=%b byte=%02h, expected rcv=%b fe=%b busy=%b byte=%02h",
                         cyc, got_v[10], got_v[9], got_v[8], got_v[7:0],
                         exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
            if (u.received) begin
                rcv_cyc.push_back(cyc);
                rcv_b.push_back(u.rx_byte);
            end
            if (u.frame_err) fe_cnt++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        u.rx_i = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold, output int p);
        p = cyc;
        evq.push_back('{p + LAT, stop_ok, b});
        if (stop_ok) wins.push_back('{p + 3, p + LAT - 1});
        else         wins.push_back('{p + 3, p + 10 * BIT + hold + 2});
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        if (stop_ok) drive(1'b1, BIT);
        else         drive(1'b0, BIT + hold);
    endtask

    task automatic glitch(input int len);
        int p;
        p = cyc;
        wins.push_back('{p + 3, p + 2 + 8 * DIV});
        drive(1'b0, len);
        drive(1'b1, 40);
    endtask

    // Frame of 0xFF interrupted by reset halfway through data bit 3.
    task automatic reset_mid();
        int p;
        p = cyc;
        wins.push_back('{p + 3, p + 4 * BIT + BIT / 2 - 1});
        drive(1'b0, BIT);
        drive(1'b1, 3 * BIT + BIT / 2);
        rst_n = 1'b0;
        mbyte = 8'h00;
        drive(1'b1, 5);
        rst_n = 1'b1;
        drive(1'b1, BIT / 2 - 5 + 5 * BIT);
    endtask

    initial begin
        int p, n0, f0;
        logic [7:0] rb;
        int r;
        bit ok;

        u.rx_i = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_busy", u.busy, 0);
        check("reset_byte", u.rx_byte, 8'h00);
        rst_n = 1'b1;

        drive(1'b1, 500);
        check("idle_byte", u.rx_byte, 8'h00);
        check("idle_strobes", rcv_cyc.size() + fe_cnt, 0);
        check("idle_busy", u.busy, 0);

        n0 = rcv_cyc.size();
        send_frame(8'h80, 1'b1, 0, p);
        drive(1'b1, 30);
        check("f80_count", rcv_cyc.size(), n0 + 1);
        if (rcv_cyc.size() == n0 + 1) begin
            check("f80_cycle", rcv_cyc[n0] - p, 611);
            check("f80_byte", rcv_b[n0], 8'h80);
        end

        n0 = rcv_cyc.size();
        send_frame(8'h80, 1'b1, 0, p);
        send_frame(8'h12, 1'b1, 0, p);
        send_frame(8'h34, 1'b1, 0, p);
        drive(1'b1, 10);
        check("b2b_count", rcv_cyc.size(), n0 + 3);
        if (rcv_cyc.size() == n0 + 3) begin
            check("b2b_gap1", rcv_cyc[n0 + 1] - rcv_cyc[n0], 640);
            check("b2b_gap2", rcv_cyc[n0 + 2] - rcv_cyc[n0 + 1], 640);
            check("b2b_b0", rcv_b[n0], 8'h80);
            check("b2b_b1", rcv_b[n0 + 1], 8'h12);
            check("b2b_b2", rcv_b[n0 + 2], 8'h34);
        end

        n0 = rcv_cyc.size();
        glitch(20);
        check("glitch_count", rcv_cyc.size(), n0);
        check("glitch_byte", u.rx_byte, 8'h34);

        n0 = rcv_cyc.size();
        f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 300, p);
        check("ferr_count", fe_cnt, f0 + 1);
        check("ferr_byte", u.rx_byte, 8'h34);
        drive(1'b1, 20);
        send_frame(8'hA3, 1'b1, 0, p);
        drive(1'b1, 10);
        check("after_ferr_count", rcv_cyc.size(), n0 + 1);
        check("after_ferr_byte", u.rx_byte, 8'hA3);

        n0 = rcv_cyc.size();
        reset_mid();
        check("rst_byte", u.rx_byte, 8'h00);
        drive(1'b1, 20);
        send_frame(8'h0F, 1'b1, 0, p);
        drive(1'b1, 10);
        check("after_rst_count", rcv_cyc.size(), n0 + 1);
        check("after_rst_byte", u.rx_byte, 8'h0F);

        for (int k = 0; k < 16; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                glitch($urandom_range(1, 28));
            end else begin
                rb = 8'($urandom);
                ok = (r != 1);
                send_frame(rb, ok, $urandom_range(0, 100), p);
                if (ok) drive(1'b1, $urandom_range(0, 30));
                else    drive(1'b1, $urandom_range(4, 30));
            end
        end

        drive(1'b1, 50);
        check("events_drained", evq.size(), 0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
